// File: rtl/dual_rate_scheduler.sv
// dual_rate_scheduler: two level-controlled tick generators arbitrated round-robin onto one valid/ready port
// Ports: clock/reset (async, active-high); run gates both period counters;
//   shift_left_n / shift_right_n speed channel n up / down by one level;
//   tick_valid/tick_chan/tick_ready form the shared tick handshake (chan 0 = channel 1);
//   level_1/level_2 report current levels; overrun/ovr_clear are sticky drop flags.
// Optional: define OVERRUN_STATUS_EN to build the overrun flags; otherwise overrun reads 2'b00.
module dual_rate_scheduler #(
  parameter int CNT_WIDTH     = 24,
  parameter int BASE_PERIOD   = 1000,
  parameter int MAX_LEVEL     = 4,
  parameter int DEFAULT_LEVEL = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       shift_left_1,
  input  logic       shift_right_1,
  input  logic       shift_left_2,
  input  logic       shift_right_2,
  output logic       tick_valid,
  output logic       tick_chan,
  input  logic       tick_ready,
  output logic [2:0] level_1,
  output logic [2:0] level_2,
  output logic [1:0] overrun,
  input  logic       ovr_clear
);
  typedef enum logic {IDLE, OFFER} state_t;
  localparam logic [CNT_WIDTH-1:0] BASE = CNT_WIDTH'(BASE_PERIOD);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
  localparam logic [2:0] LMAX = 3'(MAX_LEVEL);
  localparam logic [2:0] LDEF = 3'(DEFAULT_LEVEL);
  state_t state, state_nx;
  logic chan_nx, rr_ptr, rr_nx;
  logic [1:0] pending, fire, clr, sl, sr;
  logic [1:0][2:0] lvl;
  logic [1:0][CNT_WIDTH-1:0] cnt;
  function automatic logic [2:0] step(input logic [2:0] l, input logic dn, input logic up);
    return (dn && !up) ? (l == 3'd0 ? l : l - 3'd1) : (up && !dn) ? (l >= LMAX ? l : l + 3'd1) : l;
  endfunction
  assign sl         = {shift_left_2, shift_left_1};
  assign sr         = {shift_right_2, shift_right_1};
  assign tick_valid = state == OFFER;
  assign level_1    = lvl[0];
  assign level_2    = lvl[1];
  assign fire       = run ? {cnt[1] == '0, cnt[0] == '0} : 2'b00;
  assign clr        = (tick_valid && tick_ready) ? (tick_chan ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        lvl[i] <= LDEF;
        cnt[i] <= (BASE << LDEF) - ONE;
      end
      pending <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        lvl[i] <= step(lvl[i], sl[i], sr[i]);
        // reload uses the current level, so a level change waits for the next wrap
        if (run) cnt[i] <= fire[i] ? (BASE << lvl[i]) - ONE : cnt[i] - ONE;
      end
      // a fire on the same edge as the acceptance keeps the bit set
      pending <= fire | (pending & ~clr);
    end
  end
  always_comb begin
    state_nx = state;
    chan_nx  = tick_chan;
    rr_nx    = rr_ptr;
    if (state == IDLE) begin
      if (pending != 2'b00) begin
        state_nx = OFFER;
        chan_nx  = (&pending) ? rr_ptr : pending[1];
      end
    end else if (tick_ready) begin
      state_nx = IDLE;
      rr_nx    = ~tick_chan;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_chan <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_chan <= chan_nx;
      rr_ptr    <= rr_nx;
    end
  end
`ifdef OVERRUN_STATUS_EN
  logic [1:0] ovr, ovr_set;
  assign ovr_set = fire & pending & ~clr;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ovr <= 2'b00;
    else ovr <= ovr_set | (ovr_clear ? 2'b00 : ovr);
  end
  assign overrun = ovr;
`else
  logic unused_ovr_clear;
  assign unused_ovr_clear = ovr_clear;
  assign overrun = 2'b00;
`endif
endmodule

// File: tb/tb_dual_rate_scheduler.sv
// tb_dual_rate_scheduler: directed checks of levels, periods, arbitration, backpressure, run gating and reset
module tb_dual_rate_scheduler;
  logic clock = 1'b0, reset = 1'b1, run = 1'b0, tick_ready = 1'b0, ovr_clear = 1'b0;
  logic shift_left_1 = 1'b0, shift_right_1 = 1'b0, shift_left_2 = 1'b0, shift_right_2 = 1'b0;
  logic tick_valid, tick_chan;
  logic [2:0] level_1, level_2;
  logic [1:0] overrun;
  int errors = 0, checks = 0;
`ifdef OVERRUN_STATUS_EN
  localparam logic [1:0] OVR_BOTH = 2'b11;
`else
  localparam logic [1:0] OVR_BOTH = 2'b00;
`endif
  dual_rate_scheduler #(.CNT_WIDTH(24), .BASE_PERIOD(4), .MAX_LEVEL(3), .DEFAULT_LEVEL(0)) dut (
    .clock(clock), .reset(reset), .run(run),
    .shift_left_1(shift_left_1), .shift_right_1(shift_right_1),
    .shift_left_2(shift_left_2), .shift_right_2(shift_right_2),
    .tick_valid(tick_valid), .tick_chan(tick_chan), .tick_ready(tick_ready),
    .level_1(level_1), .level_2(level_2), .overrun(overrun), .ovr_clear(ovr_clear)
  );
  always #5 clock = ~clock;
  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic do_reset(input logic r, input logic rdy);
    reset = 1'b1;
    {shift_left_1, shift_right_1, shift_left_2, shift_right_2, ovr_clear} = '0;
    run = r;
    tick_ready = rdy;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  task automatic strobe(input logic [3:0] s);
    {shift_right_2, shift_left_2, shift_right_1, shift_left_1} = s;
    edges(1);
    {shift_right_2, shift_left_2, shift_right_1, shift_left_1} = '0;
  endtask
  task automatic test_reset;
    #1;
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", tick_valid); end
    checks++; if (tick_chan !== 1'b0) begin errors++; $display("FAIL reset_chan got=%b want=0", tick_chan); end
    checks++; if (level_1 !== 3'd0 || level_2 !== 3'd0) begin errors++; $display("FAIL reset_levels got=%0d,%0d want=0,0", level_1, level_2); end
    checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL reset_overrun got=%b want=00", overrun); end
  endtask
  task automatic test_round_robin;
    do_reset(1'b1, 1'b1);
    edges(4);
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL rr_pre_valid got=%b want=0", tick_valid); end
    for (int k = 0; k < 6; k++) begin
      edges(1);
      checks++; if (tick_valid !== 1'b1 || tick_chan !== 1'(k % 2)) begin errors++; $display("FAIL rr_offer%0d got=%b/%b want=1/%0d", k, tick_valid, tick_chan, k % 2); end
      edges(1);
      checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got=%b want=0", k, tick_valid); end
    end
    checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL rr_overrun got=%b want=00", overrun); end
  endtask
  task automatic test_levels;
    logic [2:0] exp_up [4];
    exp_up = '{3'd1, 3'd2, 3'd3, 3'd3};
    do_reset(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      strobe(4'b0010);
      checks++; if (level_1 !== exp_up[k]) begin errors++; $display("FAIL level_up%0d got=%0d want=%0d", k, level_1, exp_up[k]); end
    end
    strobe(4'b0001);
    strobe(4'b0001);
    checks++; if (level_1 !== 3'd1) begin errors++; $display("FAIL level_down got=%0d want=1", level_1); end
    strobe(4'b0010);
    strobe(4'b0011);
    checks++; if (level_1 !== 3'd2) begin errors++; $display("FAIL level_both got=%0d want=2", level_1); end
    strobe(4'b0100);
    checks++; if (level_2 !== 3'd0) begin errors++; $display("FAIL level2_floor got=%0d want=0", level_2); end
    strobe(4'b1000);
    checks++; if (level_2 !== 3'd1 || level_1 !== 3'd2) begin errors++; $display("FAIL level2_up got=%0d/%0d want=1/2", level_2, level_1); end
  endtask
  task automatic test_period;
    int first = -1, second = -1;
    do_reset(1'b0, 1'b1);
    strobe(4'b0010);
    strobe(4'b0010);
    strobe(4'b0010);
    run = 1'b1;
    for (int c = 1; c <= 80 && second < 0; c++) begin
      edges(1);
      if (tick_valid && !tick_chan) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    checks++; if (first != 5) begin errors++; $display("FAIL period_first got=%0d want=5", first); end
    checks++; if (second != 37) begin errors++; $display("FAIL period_slow got=%0d want=37", second); end
  endtask
  task automatic test_backpressure;
    do_reset(1'b1, 1'b0);
    edges(5);
    checks++; if (tick_valid !== 1'b1 || tick_chan !== 1'b0) begin errors++; $display("FAIL bp_offer got=%b/%b want=1/0", tick_valid, tick_chan); end
    for (int k = 0; k < 20; k++) begin
      edges(1);
      checks++; if (tick_valid !== 1'b1 || tick_chan !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got=%b/%b want=1/0", k, tick_valid, tick_chan); end
    end
    checks++; if (overrun !== OVR_BOTH) begin errors++; $display("FAIL bp_overrun got=%b want=%b", overrun, OVR_BOTH); end
    ovr_clear = 1'b1;
    edges(1);
    ovr_clear = 1'b0;
    checks++; if (overrun !== 2'b00) begin errors++; $display("FAIL bp_clear got=%b want=00", overrun); end
    tick_ready = 1'b1;
    edges(1);
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b want=0", tick_valid); end
    edges(1);
    checks++; if (tick_valid !== 1'b1 || tick_chan !== 1'b1) begin errors++; $display("FAIL bp_next got=%b/%b want=1/1", tick_valid, tick_chan); end
  endtask
  task automatic test_run_hold;
    do_reset(1'b1, 1'b1);
    edges(2);
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL hold_idle%0d got=%b want=0", k, tick_valid); end
    end
    run = 1'b1;
    edges(2);
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL hold_resume_early got=%b want=0", tick_valid); end
    edges(1);
    checks++; if (tick_valid !== 1'b1 || tick_chan !== 1'b0) begin errors++; $display("FAIL hold_resume got=%b/%b want=1/0", tick_valid, tick_chan); end
  endtask
  task automatic test_run_off_offer;
    do_reset(1'b1, 1'b0);
    edges(5);
    run = 1'b0;
    edges(3);
    checks++; if (tick_valid !== 1'b1 || tick_chan !== 1'b0) begin errors++; $display("FAIL off_hold got=%b/%b want=1/0", tick_valid, tick_chan); end
    tick_ready = 1'b1;
    edges(1);
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL off_accept got=%b want=0", tick_valid); end
    edges(1);
    checks++; if (tick_valid !== 1'b1 || tick_chan !== 1'b1) begin errors++; $display("FAIL off_retained got=%b/%b want=1/1", tick_valid, tick_chan); end
    edges(2);
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL off_drained got=%b want=0", tick_valid); end
  endtask
  task automatic test_reset_mid_offer;
    do_reset(1'b1, 1'b0);
    edges(5);
    strobe(4'b1000);
    checks++; if (tick_valid !== 1'b1 || level_2 !== 3'd1) begin errors++; $display("FAIL mid_setup got=%b/%0d want=1/1", tick_valid, level_2); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (tick_valid !== 1'b0 || level_2 !== 3'd0) begin errors++; $display("FAIL mid_async got=%b/%0d want=0/0", tick_valid, level_2); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    edges(4);
    checks++; if (tick_valid !== 1'b0) begin errors++; $display("FAIL mid_early got=%b want=0", tick_valid); end
    edges(1);
    checks++; if (tick_valid !== 1'b1 || tick_chan !== 1'b0) begin errors++; $display("FAIL mid_first got=%b/%b want=1/0", tick_valid, tick_chan); end
  endtask
  initial begin
    test_reset;
    test_round_robin;
    test_levels;
    test_period;
    test_backpressure;
    test_run_hold;
    test_run_off_offer;
    test_reset_mid_offer;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
